cz80_alu_seq16: RTL and testbench

Two-pass sequencer that performs Z80 16-bit arithmetic (ADD/ADC/SBC/SUB on register pairs) by driving the 8-bit cz80_alu interface.
- Low byte is processed first, then the high byte, with the carry and zero chain passed between passes.
- Sits between the CPU microcode and cz80_alu. It is the initiator side of the ALU port: it generates busa/busb/alu_op/arith16/z16/f_in and consumes q/f_out.

---
 rtl/cz80_pkg.sv | 32 +++
 rtl/cz80_alu_seq16.sv | 125 ++++++++++++
 tb/tb_cz80_alu_seq16.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cz80_pkg.sv
// Shared constants and types for the cz80 ALU and the 16-bit arithmetic sequencer.
package cz80_pkg;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_ADC = 4'd1;
   localparam logic [3:0] ALU_SUB = 4'd2;
   localparam logic [3:0] ALU_SBC = 4'd3;

   localparam int unsigned FLAG_C  = 0;
   localparam int unsigned FLAG_N  = 1;
   localparam int unsigned FLAG_PV = 2;
   localparam int unsigned FLAG_X  = 3;
   localparam int unsigned FLAG_H  = 4;
   localparam int unsigned FLAG_Y  = 5;
   localparam int unsigned FLAG_Z  = 6;
   localparam int unsigned FLAG_S  = 7;

   typedef enum logic [1:0] {
      OpAdd = 2'b00,
      OpAdc = 2'b01,
      OpSbc = 2'b10,
      OpSub = 2'b11
   } seq_op_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLo   = 2'd1,
      StHi   = 2'd2,
      StDone = 2'd3
   } seq_state_e;

endpackage

// File: rtl/cz80_alu_seq16.sv
// Two-pass 16-bit ADD/ADC/SBC/SUB sequencer driving the 8-bit cz80_alu port:
// low byte first, then high byte with the carry/zero chain carried across.
module cz80_alu_seq16
   import cz80_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [15:0] opa,
   input  logic [15:0] opb,
   input  logic [7:0]  f_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic [7:0]  f_out,
   output logic [7:0]  alu_busa,
   output logic [7:0]  alu_busb,
   output logic [3:0]  alu_op,
   output logic        alu_arith16,
   output logic        alu_z16,
   output logic [7:0]  alu_f,
   output logic [5:0]  alu_ir,
   output logic [1:0]  alu_iset,
   output logic        alu_cpi,
   input  logic [7:0]  alu_q,
   input  logic [7:0]  alu_f_out
);

   seq_state_e  state_q, state_d;
   seq_op_e     op_q;
   logic [15:0] opa_q, opb_q;
   logic [7:0]  fin_q, q_lo_q, f_lo_q;
   logic [15:0] result_q;
   logic [7:0]  f_out_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         op_q     <= OpAdd;
         opa_q    <= '0;
         opb_q    <= '0;
         fin_q    <= '0;
         q_lo_q   <= '0;
         f_lo_q   <= '0;
         result_q <= '0;
         f_out_q  <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  op_q  <= seq_op_e'(op);
                  opa_q <= opa;
                  opb_q <= opb;
                  fin_q <= f_in;
               end
            end
            StLo: begin
               q_lo_q <= alu_q;
               f_lo_q <= alu_f_out;
            end
            StHi: begin
               result_q <= {alu_q, q_lo_q};
               f_out_q  <= alu_f_out;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      alu_busa    = '0;
      alu_busb    = '0;
      alu_op      = '0;
      alu_arith16 = 1'b0;
      alu_z16     = 1'b0;
      alu_f       = '0;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StLo;
         end
         StLo: begin
            state_d  = StHi;
            alu_busa = opa_q[7:0];
            alu_busb = opb_q[7:0];
            alu_f    = fin_q;
            unique case (op_q)
               OpAdd:   alu_op = ALU_ADD;
               OpAdc:   alu_op = ALU_ADC;
               OpSbc:   alu_op = ALU_SBC;
               default: alu_op = ALU_SUB;
            endcase
         end
         StHi: begin
            state_d  = StDone;
            alu_busa = opa_q[15:8];
            alu_busb = opb_q[15:8];
            alu_op   = ((op_q == OpAdd) || (op_q == OpAdc)) ? ALU_ADC : ALU_SBC;
            // 16-bit ADD keeps the caller's S/Z/PV; the others build a 16-bit zero via z16
            if (op_q == OpAdd) begin
               alu_arith16 = 1'b1;
               alu_f       = {fin_q[7:1], f_lo_q[FLAG_C]};
            end else begin
               alu_z16 = 1'b1;
               alu_f   = f_lo_q;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy     = (state_q != StIdle);
   assign done     = (state_q == StDone);
   assign result   = result_q;
   assign f_out    = f_out_q;
   assign alu_ir   = '0;
   assign alu_iset = '0;
   assign alu_cpi  = 1'b0;

endmodule

// File: tb/tb_cz80_alu_seq16.sv
// Randomized bench for cz80_alu_seq16 with a behavioural 8-bit ALU stand-in and
// a 16-bit arithmetic reference model.
module tb_cz80_alu_seq16;
   import cz80_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = '0;
   logic [15:0] opa = '0, opb = '0;
   logic [7:0]  f_in = '0;
   logic        busy, done;
   logic [15:0] result;
   logic [7:0]  f_out;
   logic [7:0]  alu_busa, alu_busb, alu_f, alu_q, alu_f_out;
   logic [3:0]  alu_op;
   logic        alu_arith16, alu_z16, alu_cpi;
   logic [5:0]  alu_ir;
   logic [1:0]  alu_iset;

   int n_vec = 0;
   int n_err = 0;
   bit tie_bad = 1'b0;
   bit idle_bad = 1'b0;

   always #5 clk = ~clk;

   cz80_alu_seq16 dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .opa(opa), .opb(opb),
      .f_in(f_in), .busy(busy), .done(done), .result(result), .f_out(f_out),
      .alu_busa(alu_busa), .alu_busb(alu_busb), .alu_op(alu_op),
      .alu_arith16(alu_arith16), .alu_z16(alu_z16), .alu_f(alu_f), .alu_ir(alu_ir),
      .alu_iset(alu_iset), .alu_cpi(alu_cpi), .alu_q(alu_q), .alu_f_out(alu_f_out)
   );

   // Behavioural 8-bit add/sub ALU answering the sequencer's requests
   logic       sub8, cin8, v8;
   logic [7:0] bb8, q8;
   logic [8:0] s8;
   logic [4:0] h8;
   always_comb begin
      sub8 = (alu_op == ALU_SUB) || (alu_op == ALU_SBC);
      cin8 = ((alu_op == ALU_ADC) || (alu_op == ALU_SBC)) ? alu_f[FLAG_C] : 1'b0;
      bb8  = sub8 ? ~alu_busb : alu_busb;
      s8   = {1'b0, alu_busa} + {1'b0, bb8} + {8'd0, cin8 ^ sub8};
      h8   = {1'b0, alu_busa[3:0]} + {1'b0, bb8[3:0]} + {4'd0, cin8 ^ sub8};
      q8   = s8[7:0];
      v8   = (alu_busa[7] == bb8[7]) && (q8[7] != alu_busa[7]);
      alu_q = q8;
      alu_f_out = '0;
      alu_f_out[FLAG_C] = s8[8] ^ sub8;
      alu_f_out[FLAG_H] = h8[4] ^ sub8;
      alu_f_out[FLAG_N] = sub8;
      alu_f_out[FLAG_X] = q8[3];
      alu_f_out[FLAG_Y] = q8[5];
      if (alu_arith16) begin
         alu_f_out[FLAG_S]  = alu_f[FLAG_S];
         alu_f_out[FLAG_Z]  = alu_f[FLAG_Z];
         alu_f_out[FLAG_PV] = alu_f[FLAG_PV];
      end else begin
         alu_f_out[FLAG_S]  = q8[7];
         alu_f_out[FLAG_Z]  = (q8 == 8'd0) ? (alu_z16 ? alu_f[FLAG_Z] : 1'b1) : 1'b0;
         alu_f_out[FLAG_PV] = v8;
      end
   end

   always @(negedge clk) begin
      if (alu_ir != 6'd0 || alu_iset != 2'd0 || alu_cpi) tie_bad <= 1'b1;
      if ((!busy || done) &&
          ({alu_busa, alu_busb, alu_op, alu_arith16, alu_z16, alu_f} != 30'd0))
         idle_bad <= 1'b1;
   end

   // 16-bit Z80 reference: returns {flags, result}
   function automatic logic [23:0] ref16(input logic [1:0] o, input logic [15:0] a,
                                         input logic [15:0] b, input logic [7:0] f);
      int ai, bi, ci, r;
      logic [15:0] q;
      logic [7:0]  fo;
      logic        v;
      ai = int'(a);
      bi = int'(b);
      ci = (o == 2'b01 || o == 2'b10) ? int'(f[FLAG_C]) : 0;
      fo = '0;
      if (!o[1]) begin
         r = ai + bi + ci;
         fo[FLAG_C] = (r > 65535);
         fo[FLAG_H] = (((ai & 4095) + (bi & 4095) + ci) > 4095);
         q = r[15:0];
         v = (a[15] == b[15]) && (q[15] != a[15]);
      end else begin
         r = ai - bi - ci;
         fo[FLAG_C] = (r < 0);
         fo[FLAG_H] = (((ai & 4095) - (bi & 4095) - ci) < 0);
         q = r[15:0];
         v = (a[15] != b[15]) && (q[15] != a[15]);
      end
      fo[FLAG_N] = o[1];
      fo[FLAG_X] = q[11];
      fo[FLAG_Y] = q[13];
      if (o == 2'b00) begin
         fo[FLAG_S]  = f[FLAG_S];
         fo[FLAG_Z]  = f[FLAG_Z];
         fo[FLAG_PV] = f[FLAG_PV];
      end else begin
         fo[FLAG_S]  = q[15];
         fo[FLAG_Z]  = (q == 16'd0);
         fo[FLAG_PV] = v;
      end
      return {fo, q};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] f, input bit chk_lat,
                         output logic [15:0] res, output logic [7:0] fl);
      int lat;
      bit seen;
      @(negedge clk);
      op = o; opa = a; opb = b; f_in = f; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      op = 2'($urandom); opa = 16'($urandom); opb = 16'($urandom); f_in = 8'($urandom);
      seen = 1'b0;
      lat = 0;
      for (int k = 1; k <= 8 && !seen; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            seen = 1'b1;
            lat = k;
         end
      end
      check("done_seen", 32'(seen), 32'd1);
      if (chk_lat) check("latency", lat, 2);
      res = result;
      fl  = f_out;
      @(posedge clk);
      #1;
      if (chk_lat) check("done_width", 32'(done), 32'd0);
   endtask

   logic [15:0] res;
   logic [7:0]  fl;
   logic [23:0] exp;
   logic [1:0]  vo [6];
   logic [15:0] va [6], vb [6];
   logic [7:0]  vf [6];
   logic [15:0] rres [2];
   logic [7:0]  rf [2];
   int          ndone;
   bit          saw_done;

   initial begin
      #2;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_f_out", 32'(f_out), 32'd0);
      check("rst_alu", {alu_busa, alu_busb, alu_f, alu_op, alu_arith16, alu_z16, 2'b00},
            32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      run_op(2'b00, 16'h1234, 16'h0FFF, 8'hFF, 1'b1, res, fl);
      check("add_result", 32'(res), 32'h2233);
      check("add_flags", 32'(fl), 32'hF4);

      run_op(2'b10, 16'h0000, 16'h0001, 8'h00, 1'b1, res, fl);
      check("sbc_borrow_result", 32'(res), 32'hFFFF);
      check("sbc_borrow_flags", 32'(fl & 8'hD3), 32'h93);
      exp = ref16(2'b10, 16'h0000, 16'h0001, 8'h00);
      check("sbc_borrow_model", 32'(fl), 32'(exp[23:16]));

      run_op(2'b01, 16'h8000, 16'h8000, 8'h01, 1'b0, res, fl);
      check("adc_ovf_result", 32'(res), 32'h0001);
      check("adc_ovf_flags", 32'(fl & 8'h47), 32'h05);

      run_op(2'b10, 16'h1234, 16'h1234, 8'h00, 1'b0, res, fl);
      check("sbc_zero_result", 32'(res), 32'h0000);
      check("sbc_zero_flags", 32'(fl & 8'h43), 32'h42);

      run_op(2'b11, 16'h0100, 16'h0001, 8'hFF, 1'b0, res, fl);
      check("sub_result", 32'(res), 32'h00FF);
      check("sub_zflag", 32'(fl & 8'h40), 32'h00);

      // start held high with operands changing every cycle
      for (int c = 0; c < 6; c++) begin
         vo[c] = 2'($urandom); va[c] = 16'($urandom);
         vb[c] = 16'($urandom); vf[c] = 8'($urandom);
      end
      ndone = 0;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (c < 6) begin
            start = 1'b1; op = vo[c]; opa = va[c]; opb = vb[c]; f_in = vf[c];
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         if (done) begin
            if (ndone < 2) begin
               rres[ndone] = result;
               rf[ndone]   = f_out;
            end
            ndone++;
         end
      end
      check("held_ops", ndone, 2);
      exp = ref16(vo[0], va[0], vb[0], vf[0]);
      check("held_res0", 32'(rres[0]), 32'(exp[15:0]));
      check("held_flg0", 32'(rf[0]), 32'(exp[23:16]));
      exp = ref16(vo[4], va[4], vb[4], vf[4]);
      check("held_res1", 32'(rres[1]), 32'(exp[15:0]));
      check("held_flg1", 32'(rf[1]), 32'(exp[23:16]));

      // reset asserted while the high byte is in flight
      @(negedge clk);
      op = 2'b01; opa = 16'hFFFF; opb = 16'h0001; f_in = 8'h01; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_result", 32'(result), 32'd0);
      check("abort_f_out", 32'(f_out), 32'd0);
      check("abort_alu_busa", 32'(alu_busa), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      saw_done = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         if (done) saw_done = 1'b1;
      end
      check("abort_no_done", 32'(saw_done), 32'd0);

      for (int i = 0; i < 10000; i++) begin
         logic [1:0]  ro;
         logic [15:0] ra, rb;
         logic [7:0]  rfi;
         ro = 2'($urandom); ra = 16'($urandom); rb = 16'($urandom); rfi = 8'($urandom);
         if (i % 16 == 0) rb = ra;
         run_op(ro, ra, rb, rfi, 1'b0, res, fl);
         exp = ref16(ro, ra, rb, rfi);
         check("rnd_result", 32'(res), 32'(exp[15:0]));
         check("rnd_flags", 32'(fl), 32'(exp[23:16]));
      end

      check("alu_tie_offs", 32'(tie_bad), 32'd0);
      check("alu_idle_zero", 32'(idle_bad), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
